// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU: sizes, loader state encoding and
// instruction field helpers.
package cpu_pkg;

  localparam int CPU_AW    = 8;
  localparam int CPU_DW    = 9;
  localparam int CPU_DEPTH = 2 ** CPU_AW;

  localparam logic [CPU_DW-1:0] CPU_FILL_WORD = 9'h000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } load_state_t;

  // Instruction layout: {opcode[2:0], ra1[1:0], ra2[1:0], wa[1:0]}
  function automatic logic [2:0] instr_opcode(input logic [CPU_DW-1:0] word);
    return word[8:6];
  endfunction

  function automatic logic [1:0] instr_ra1(input logic [CPU_DW-1:0] word);
    return word[5:4];
  endfunction

  function automatic logic [1:0] instr_ra2(input logic [CPU_DW-1:0] word);
    return word[3:2];
  endfunction

  function automatic logic [1:0] instr_wa(input logic [CPU_DW-1:0] word);
    return word[1:0];
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port,
// contents deliberately left unreset.
module imem_ram
  import cpu_pkg::*;
#(
  parameter int AW    = CPU_AW,
  parameter int DW    = CPU_DW,
  parameter int DEPTH = CPU_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Host-side loader and instruction responder: clears the program RAM, streams
// a new program in, releases the CPU and parks when it reports done.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int            AW        = CPU_AW,
  parameter int            DW        = CPU_DW,
  parameter int            DEPTH     = CPU_DEPTH,
  parameter logic [DW-1:0] FILL_WORD = CPU_FILL_WORD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr,
  output logic          cpu_run,
  input  logic          cpu_done,
  output logic          busy,
  output logic          halted,
  output logic [AW:0]   prog_len,
  output logic          ovf_err
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  load_state_t   state;
  logic [AW-1:0] clr_ptr;
  logic [AW:0]   wr_ptr;
  logic          handshake;
  logic          room;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  assign load_ready = (state == S_LOAD);
  assign cpu_run    = (state == S_RUN);
  assign halted     = (state == S_HALT);
  assign busy       = (state == S_CLEAR) | (state == S_LOAD);

  assign handshake = load_valid & load_ready;
  assign room      = (wr_ptr < DEPTH_CNT);

  // A word arriving together with load_start is discarded, never written.
  assign ram_we    = (state == S_CLEAR) | (handshake & room & ~load_start);
  assign ram_waddr = (state == S_CLEAR) ? clr_ptr : wr_ptr[AW-1:0];
  assign ram_wdata = (state == S_CLEAR) ? FILL_WORD : load_data;

  assign instr = cpu_run ? ram_rdata : FILL_WORD;

  imem_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (pc),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      clr_ptr  <= '0;
      wr_ptr   <= '0;
      prog_len <= '0;
      ovf_err  <= 1'b0;
    end else if (load_start && state != S_CLEAR) begin
      state    <= S_CLEAR;
      clr_ptr  <= '0;
      prog_len <= '0;
      ovf_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            if (room) wr_ptr  <= wr_ptr + 1'b1;
            else      ovf_err <= 1'b1;
            // prog_len saturates because wr_ptr stops at DEPTH
            if (load_last) begin
              state    <= S_RUN;
              prog_len <= room ? wr_ptr + 1'b1 : wr_ptr;
            end
          end
        end
        S_RUN: begin
          if (cpu_done) state <= S_HALT;
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear/load/run sequencing, gaps, overflow,
// done/reload, asynchronous reset and aborts.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [8:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] pc;
  logic [8:0] instr;
  logic       cpu_run;
  logic       cpu_done;
  logic       busy;
  logic       halted;
  logic [8:0] prog_len;
  logic       ovf_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc         (pc),
    .instr      (instr),
    .cpu_run    (cpu_run),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .halted     (halted),
    .prog_len   (prog_len),
    .ovf_err    (ovf_err)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input string tag, input logic [7:0] addr, input logic [8:0] exp);
    pc = addr;
    #1;
    check_vec(tag, 32'(instr), 32'(exp));
  endtask

  // Pulse load_start and ride through the 256-cycle clear into LOAD.
  task automatic start_load(input string tag);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_vec({tag, "_busy"}, 32'(busy), 32'd1);
    check_vec({tag, "_rdy_clr"}, 32'(load_ready), 32'd0);
    repeat (255) step();
    check_vec({tag, "_rdy_end_clr"}, 32'(load_ready), 32'd0);
    step();
    check_vec({tag, "_rdy_load"}, 32'(load_ready), 32'd1);
  endtask

  task automatic drive(input logic valid, input logic [8:0] data, input logic last);
    load_valid = valid;
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_run"}, 32'(cpu_run), 32'd0);
    check_vec({tag, "_rdy"}, 32'(load_ready), 32'd0);
    check_vec({tag, "_busy"}, 32'(busy), 32'd0);
    check_vec({tag, "_halt"}, 32'(halted), 32'd0);
    check_vec({tag, "_len"}, 32'(prog_len), 32'd0);
    check_vec({tag, "_ovf"}, 32'(ovf_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; pc = '0; cpu_done = 1'b0;
    repeat (3) step();
    check_reset_outputs("init_rst");
    reset = 1'b0;
    step();

    // Basic load and run
    start_load("basic");
    drive(1'b1, 9'h0A1, 1'b0);
    drive(1'b1, 9'h123, 1'b0);
    drive(1'b1, 9'h1FF, 1'b1);
    check_vec("basic_run", 32'(cpu_run), 32'd1);
    check_vec("basic_len", 32'(prog_len), 32'd3);
    read_at("basic_pc0", 8'd0, 9'h0A1);
    read_at("basic_pc1", 8'd1, 9'h123);
    read_at("basic_pc2", 8'd2, 9'h1FF);
    read_at("basic_pc3", 8'd3, 9'h000);
    read_at("basic_pc255", 8'd255, 9'h000);

    // Gaps in load_valid; load_last without valid must be ignored
    start_load("gap");
    drive(1'b1, 9'h011, 1'b0);
    drive(1'b0, 9'h022, 1'b1);
    check_vec("gap_last_ignored", 32'(load_ready), 32'd1);
    drive(1'b0, 9'h033, 1'b0);
    drive(1'b1, 9'h044, 1'b0);
    drive(1'b1, 9'h055, 1'b1);
    check_vec("gap_run", 32'(cpu_run), 32'd1);
    check_vec("gap_len", 32'(prog_len), 32'd3);
    read_at("gap_pc0", 8'd0, 9'h011);
    read_at("gap_pc1", 8'd1, 9'h044);
    read_at("gap_pc2", 8'd2, 9'h055);
    read_at("gap_pc3", 8'd3, 9'h000);

    // Overflow: 258 words offered
    start_load("ovf");
    for (int i = 0; i < 258; i++) drive(1'b1, 9'(i), (i == 257));
    check_vec("ovf_run", 32'(cpu_run), 32'd1);
    check_vec("ovf_flag", 32'(ovf_err), 32'd1);
    check_vec("ovf_len", 32'(prog_len), 32'd256);
    read_at("ovf_pc0", 8'd0, 9'h000);
    read_at("ovf_pc1", 8'd1, 9'h001);
    read_at("ovf_pc127", 8'd127, 9'h07F);
    read_at("ovf_pc255", 8'd255, 9'h0FF);

    // Done parks the CPU, results retained
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    check_vec("done_run", 32'(cpu_run), 32'd0);
    check_vec("done_halt", 32'(halted), 32'd1);
    check_vec("done_len", 32'(prog_len), 32'd256);
    check_vec("done_ovf", 32'(ovf_err), 32'd1);
    read_at("done_instr_fill", 8'd5, 9'h000);

    // Mid-cycle asynchronous reset from HALT
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("halt_rst");
    reset = 1'b0;
    step();

    // Reload after halt: old program must be gone
    start_load("reload");
    drive(1'b1, 9'h155, 1'b1);
    check_vec("reload_run", 32'(cpu_run), 32'd1);
    check_vec("reload_len", 32'(prog_len), 32'd1);
    read_at("reload_pc1", 8'd1, 9'h000);
    read_at("reload_pc0", 8'd0, 9'h155);

    // Abort a load with reset after two words
    start_load("abort");
    drive(1'b1, 9'h0AA, 1'b0);
    drive(1'b1, 9'h0BB, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("load_rst");
    reset = 1'b0;
    step();

    start_load("post");
    drive(1'b1, 9'h0A1, 1'b1);
    check_vec("post_run", 32'(cpu_run), 32'd1);
    check_vec("post_len", 32'(prog_len), 32'd1);
    read_at("post_pc0", 8'd0, 9'h0A1);
    read_at("post_pc1", 8'd1, 9'h000);

    // load_start beats a coincident cpu_done in RUN
    load_start = 1'b1;
    cpu_done   = 1'b1;
    step();
    load_start = 1'b0;
    cpu_done   = 1'b0;
    check_vec("runabort_run", 32'(cpu_run), 32'd0);
    check_vec("runabort_busy", 32'(busy), 32'd1);
    check_vec("runabort_halt", 32'(halted), 32'd0);
    check_vec("runabort_len", 32'(prog_len), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
